wb_stage_pipe: RTL and testbench
================================

WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 16: width of result data.
REQ-002 Parameter RADDR_W, default 3: width of register-file destination address.
REQ-003 Parameter CNT_W, default 16: width of the retire counter.
REQ-004 Port clk  in  1: clock; all state updates on its rising edge.
REQ-005 Port reset  in  1: reset, synchronous, active-low.
REQ-006 Port mem_valid  in  1: memory stage presents an instruction result.
REQ-007 Port mem_ready  out  1: stage can accept a result this cycle.
REQ-008 Port mem_alu_res  in  DATA_W: ALU result.
REQ-009 Port mem_load_data  in  DATA_W: data-memory load result.
REQ-010 Port mem_sel_load  in  1: 1 selects mem_load_data, 0 selects mem_alu_res.
REQ-011 Port mem_rd  in  RADDR_W: destination register.
REQ-012 Port mem_wr_en  in  1: instruction writes a register.
REQ-013 Port flush  in  1: discard all buffered, unretired results.
REQ-014 Port rf_busy  in  1: register file cannot accept a write this cycle.
REQ-015 Port rf_we / rf_waddr / rf_wdata  out  1 / RADDR_W / DATA_W: register-file write port.
REQ-016 Port ans_wb  out  DATA_W: registered data of the most recent retired write.
REQ-017 Port retire_cnt  out  CNT_W: count of retired instructions.
REQ-018 Port fwd_valid / fwd_addr / fwd_data  out  1 / RADDR_W / DATA_W: bypass to decode.

Function
REQ-019 Stage SHALL be a 2-entry in-order buffer; FSM states EMPTY, ONE, TWO.
REQ-020 mem_ready SHALL be 1 in EMPTY and ONE, 0 in TWO and while reset is low.
REQ-021 Push SHALL occur when mem_valid & mem_ready & !flush; entry stores {sel-muxed data, mem_rd, mem_wr_en}; mux resolved at capture.
REQ-022 Pop SHALL occur when state != EMPTY & !rf_busy & !flush; head entry retires.
REQ-023 Transitions: push only -> occupancy +1; pop only -> -1; push & pop -> unchanged, and in ONE the new entry becomes head.
REQ-024 rf_we SHALL be 1 only on a pop whose entry has wr_en=1 and rd != 0; rf_waddr/rf_wdata SHALL equal the head entry; otherwise rf_we=0 and the other port outputs are 0.
REQ-025 Latency: a result pushed in cycle N SHALL drive rf_we in cycle N+1 if buffer was EMPTY and rf_busy=0.
REQ-026 Entries with wr_en=0 or rd=0 SHALL still pop and count as retired.
REQ-027 ans_wb SHALL load rf_wdata on each cycle with rf_we=1, else hold.
REQ-028 retire_cnt SHALL increment by 1 per pop and wrap from 2^CNT_W-1 to 0.
REQ-029 flush SHALL force EMPTY next cycle, override a simultaneous push and pop, suppress rf_we that cycle, and leave ans_wb and retire_cnt unchanged.
REQ-030 rf_busy held high SHALL hold all entries; no data loss or duplication.

Reset
REQ-031 With reset low at a clock edge: state EMPTY, ans_wb=0, retire_cnt=0, entries cleared; rf_we, fwd_valid=0.
REQ-032 Reset mid-operation SHALL discard buffered results without any register-file write.

Configuration
REQ-033 Macro WB_FWD_EN defined: fwd_valid=1 when any buffered entry has wr_en=1 and rd != 0; fwd_addr/fwd_data SHALL come from the youngest such entry.
REQ-034 WB_FWD_EN undefined: forwarding ports SHALL remain present and be tied to 0; no forwarding logic.

Structure
REQ-035 Package wb_pkg SHALL hold the FSM state type (EMPTY/ONE/TWO) and default width constants.
REQ-036 Sub-module wb_skid_buf SHALL implement the 2-entry storage and FSM; the top-level holds the mux, retire logic, counter, and forwarding.

Verification
REQ-037 Reset, then push alu=16'h1234, rd=3, wr_en=1, sel=0 -> next cycle rf_we=1, waddr=3, wdata=16'h1234; following cycle ans_wb=16'h1234, retire_cnt=1.
REQ-038 rf_busy=1, three back-to-back pushes -> mem_ready=0 after the second push; on release, two in-order writes, third accepted.
REQ-039 Push rd=0, wr_en=1 -> rf_we stays 0, retire_cnt increments.
REQ-040 Two entries buffered, flush=1 with mem_valid=1 -> EMPTY next cycle, no rf_we, retire_cnt unchanged.
REQ-041 CNT_W=4, 17 retirements -> retire_cnt=1; with WB_FWD_EN, buffered rd=5 data=16'hBEEF -> fwd_valid=1, fwd_addr=5, fwd_data=16'hBEEF.

Source files
------------

// File: rtl/wb_stage_pipe_pkg.sv
// Shared types and default widths for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int RADDR_W_DEF = 3;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// Memory-stage to writeback-stage result handshake (valid/ready plus result fields).
interface wb_stage_pipe_if #(
  parameter int DATA_W  = wb_pkg::DATA_W_DEF,
  parameter int RADDR_W = wb_pkg::RADDR_W_DEF
);
  logic               mem_valid;
  logic               mem_ready;
  logic [DATA_W-1:0]  mem_alu_res;
  logic [DATA_W-1:0]  mem_load_data;
  logic               mem_sel_load;
  logic [RADDR_W-1:0] mem_rd;
  logic               mem_wr_en;

  modport master (
    output mem_valid, mem_alu_res, mem_load_data, mem_sel_load, mem_rd, mem_wr_en,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_alu_res, mem_load_data, mem_sel_load, mem_rd, mem_wr_en,
    output mem_ready
  );
endinterface

// File: rtl/wb_skid_buf.sv
// Two-entry in-order buffer with EMPTY/ONE/TWO FSM; entry 0 is always the head.
// Ready is low when full or in reset; the tail port exists only with WB_FWD_EN.
module wb_skid_buf
  import wb_pkg::*;
#(
  parameter int ENT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [ENT_W-1:0] in_ent,
  output wb_state_t        state,
  output logic             ready,
  output logic [ENT_W-1:0] head
`ifdef WB_FWD_EN
  ,
  output logic [ENT_W-1:0] tail
`endif
);

  logic [ENT_W-1:0] ent0;
  logic [ENT_W-1:0] ent1;
  logic             rdy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
      ent0  <= '0;
      ent1  <= '0;
      rdy_q <= 1'b1;
    end else if (flush) begin
      state <= EMPTY;
      ent0  <= '0;
      ent1  <= '0;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            ent0  <= in_ent;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              ent1  <= in_ent;
              state <= TWO;
              rdy_q <= 1'b0;
            end
            2'b01: begin
              ent0  <= '0;
              state <= EMPTY;
            end
            // Head retires and the incoming result takes its place.
            2'b11: ent0 <= in_ent;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            ent0  <= ent1;
            ent1  <= '0;
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = reset & rdy_q;
  assign head  = ent0;
`ifdef WB_FWD_EN
  assign tail  = ent1;
`endif

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: result mux, 2-deep buffer, register-file retire, retire counter, optional bypass (WB_FWD_EN).
// Write appears one cycle after capture into an empty buffer; stalls on rf_busy, mem_ready drops when full.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  wb_stage_pipe_if.slave     mem,
  input  logic               flush,
  input  logic               rf_busy,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0]  ans_wb,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]  fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [RADDR_W-1:0] rd;
    logic               wr_en;
  } ent_t;

  localparam int ENT_W = $bits(ent_t);

  ent_t      in_ent;
  ent_t      head;
  wb_state_t state;
  logic      buf_ready;
  logic      push;
  logic      pop;

  always_comb begin
    in_ent       = '0;
    in_ent.data  = mem.mem_sel_load ? mem.mem_load_data : mem.mem_alu_res;
    in_ent.rd    = mem.mem_rd;
    in_ent.wr_en = mem.mem_wr_en;
  end

  assign mem.mem_ready = buf_ready;
  assign push = mem.mem_valid & buf_ready & ~flush;
  // Gating with reset keeps a mid-operation reset from leaking a write.
  assign pop  = reset & (state != EMPTY) & ~rf_busy & ~flush;

`ifdef WB_FWD_EN
  ent_t tail;
`endif

  wb_skid_buf #(
    .ENT_W (ENT_W)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .in_ent (in_ent),
    .state  (state),
    .ready  (buf_ready),
    .head   (head)
`ifdef WB_FWD_EN
    ,
    .tail   (tail)
`endif
  );

  assign rf_we    = pop & head.wr_en & (head.rd != '0);
  assign rf_waddr = rf_we ? head.rd   : '0;
  assign rf_wdata = rf_we ? head.data : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ans_wb     <= '0;
      retire_cnt <= '0;
    end else begin
      if (rf_we) ans_wb <= rf_wdata;
      if (pop)   retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

`ifdef WB_FWD_EN
  // Youngest writing entry wins, so the tail is considered before the head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (state == TWO && tail.wr_en && tail.rd != '0) begin
      fwd_valid = 1'b1;
      fwd_addr  = tail.rd;
      fwd_data  = tail.data;
    end else if (state != EMPTY && head.wr_en && head.rd != '0) begin
      fwd_valid = 1'b1;
      fwd_addr  = head.rd;
      fwd_data  = head.data;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe (CNT_W=4 so counter wrap is reachable); queue-based reference model.
module tb_wb_stage_pipe;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          rf_busy;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] ans_wb;
  logic [CW-1:0] retire_cnt;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  always #5 clk = ~clk;

  wb_stage_pipe_if #(.DATA_W(DW), .RADDR_W(AW)) mif ();

  wb_stage_pipe #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mif),
    .flush      (flush),
    .rf_busy    (rf_busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .ans_wb     (ans_wb),
    .retire_cnt (retire_cnt),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data)
  );

  typedef struct {
    logic          rst_n, valid, sel, wr, flush, busy;
    logic [DW-1:0] alu, ld;
    logic [AW-1:0] rd;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          e_rdy, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_ans;
    logic [CW-1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          wr;
  } ment_t;

  ment_t       q[$];
  logic [DW-1:0] m_ans;
  int          m_cnt;
  int          total, passed, cyc;

  logic          a_rdy, a_we, a_fv;
  logic [AW-1:0] a_addr, a_fa;
  logic [DW-1:0] a_data, a_ans, a_fd;
  logic [CW-1:0] a_cnt;

  function automatic stim_t mk(input logic rst_n, input logic valid, input logic [DW-1:0] alu,
                               input logic [DW-1:0] ld, input logic sel, input logic [AW-1:0] rd,
                               input logic wr, input logic fl, input logic busy);
    stim_t s;
    s.rst_n = rst_n; s.valid = valid; s.alu = alu; s.ld = ld; s.sel = sel;
    s.rd = rd; s.wr = wr; s.flush = fl; s.busy = busy;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic e_rdy, input logic e_we,
                               input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
                               input logic [DW-1:0] e_ans, input logic [CW-1:0] e_cnt);
    vec_t v;
    v.s = s; v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr;
    v.e_data = e_data; v.e_ans = e_ans; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle, sample mid-cycle, compare against the model, then advance the model.
  task automatic step(input stim_t s);
    bit            m_ready, m_pop, m_we, m_fv;
    logic [AW-1:0] m_addr, m_fa;
    logic [DW-1:0] m_data, m_fd;
    ment_t         e;
    @(negedge clk);
    reset = s.rst_n;
    mif.mem_valid = s.valid; mif.mem_alu_res = s.alu; mif.mem_load_data = s.ld;
    mif.mem_sel_load = s.sel; mif.mem_rd = s.rd; mif.mem_wr_en = s.wr;
    flush = s.flush; rf_busy = s.busy;
    #1;
    cyc++;
    a_rdy = mif.mem_ready; a_we = rf_we; a_addr = rf_waddr; a_data = rf_wdata;
    a_ans = ans_wb; a_cnt = retire_cnt; a_fv = fwd_valid; a_fa = fwd_addr; a_fd = fwd_data;

    m_ready = s.rst_n && (q.size() < 2);
    m_pop   = s.rst_n && (q.size() > 0) && !s.busy && !s.flush;
    m_we = 1'b0; m_addr = '0; m_data = '0;
    if (m_pop && q[0].wr && q[0].rd != 0) begin
      m_we = 1'b1; m_addr = q[0].rd; m_data = q[0].data;
    end
    m_fv = 1'b0; m_fa = '0; m_fd = '0;
    if (FWD) begin
      foreach (q[i]) if (q[i].wr && q[i].rd != 0) begin
        m_fv = 1'b1; m_fa = q[i].rd; m_fd = q[i].data;
      end
    end

    chk("mem_ready", a_rdy, m_ready);
    chk("rf_we", a_we, m_we);
    chk("rf_waddr", a_addr, m_addr);
    chk("rf_wdata", a_data, m_data);
    chk("ans_wb", a_ans, m_ans);
    chk("retire_cnt", a_cnt, m_cnt);
    chk("fwd_valid", a_fv, m_fv);
    chk("fwd_addr", a_fa, m_fa);
    chk("fwd_data", a_fd, m_fd);

    if (!s.rst_n) begin
      q.delete(); m_ans = '0; m_cnt = 0;
    end else if (s.flush) begin
      q.delete();
    end else begin
      if (m_we) m_ans = m_data;
      if (m_pop) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (s.valid && m_ready) begin
        e.data = s.sel ? s.ld : s.alu; e.rd = s.rd; e.wr = s.wr;
        q.push_back(e);
      end
    end
  endtask

  vec_t  tbl[$];
  stim_t idle, rst, rs;

  initial begin
    total = 0; passed = 0; cyc = 0;
    m_ans = '0; m_cnt = 0;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed cycle table: stimulus and hand-derived expectations (sampled before the edge).
    tbl.push_back(mkv(rst, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(mk(1, 1, 16'h1234, 16'h5555, 0, 3, 1, 0, 0), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(idle, 1, 1, 3, 16'h1234, 0, 0));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 16'h1234, 1));
    tbl.push_back(mkv(mk(1, 1, 16'h1111, 0, 0, 1, 1, 0, 1), 1, 0, 0, 0, 16'h1234, 1));
    tbl.push_back(mkv(mk(1, 1, 16'h2222, 16'hAAAA, 1, 2, 1, 0, 1), 1, 0, 0, 0, 16'h1234, 1));
    tbl.push_back(mkv(mk(1, 1, 16'h3333, 0, 0, 4, 1, 0, 1), 0, 0, 0, 0, 16'h1234, 1));
    tbl.push_back(mkv(mk(1, 1, 16'h3333, 0, 0, 4, 1, 0, 0), 0, 1, 1, 16'h1111, 16'h1234, 1));
    tbl.push_back(mkv(mk(1, 1, 16'h3333, 0, 0, 4, 1, 0, 0), 1, 1, 2, 16'hAAAA, 16'h1111, 2));
    tbl.push_back(mkv(idle, 1, 1, 4, 16'h3333, 16'hAAAA, 3));
    tbl.push_back(mkv(mk(1, 1, 16'h7777, 0, 0, 0, 1, 0, 0), 1, 0, 0, 0, 16'h3333, 4));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 16'h3333, 4));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(mk(1, 1, 16'h0101, 0, 0, 5, 1, 0, 1), 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(mk(1, 1, 16'h0202, 0, 0, 6, 1, 0, 1), 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(mk(1, 1, 16'h0303, 0, 0, 7, 1, 1, 0), 0, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(mk(1, 1, 16'h0404, 0, 0, 1, 1, 0, 0), 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(mk(1, 1, 16'h0505, 0, 0, 2, 1, 1, 0), 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(mk(1, 1, 16'h0606, 0, 0, 3, 1, 0, 1), 1, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(rst, 0, 0, 0, 0, 16'h3333, 5));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(mk(1, 1, 16'h0909, 0, 0, 2, 0, 0, 0), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(idle, 1, 0, 0, 0, 0, 1));

    reset = 1'b0; flush = 1'b0; rf_busy = 1'b0;
    mif.mem_valid = 1'b0; mif.mem_alu_res = '0; mif.mem_load_data = '0;
    mif.mem_sel_load = 1'b0; mif.mem_rd = '0; mif.mem_wr_en = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      chk($sformatf("tbl%0d_ready", i), a_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_we", i), a_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_waddr", i), a_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_wdata", i), a_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_ans", i), a_ans, tbl[i].e_ans);
      chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].e_cnt);
    end

    // 17 back-to-back retirements from reset wrap the 4-bit counter to 1.
    step(rst);
    for (int i = 0; i <= 16; i++)
      step(mk(1, 1, DW'(i * 16'h0111), 0, 0, AW'((i % 7) + 1), 1, 0, 0));
    step(idle);
    step(idle);
    chk("wrap_cnt", a_cnt, 1);
    chk("wrap_ans", a_ans, 16'h1110);

    // Bypass: youngest writing entry is reported; an rd=0 entry behind it is ignored.
    step(rst);
    step(mk(1, 1, 16'hBEEF, 0, 0, 5, 1, 0, 1));
    step(mk(1, 1, 16'h1234, 0, 0, 0, 1, 0, 1));
    chk("fwd1_valid", a_fv, FWD);
    chk("fwd1_addr", a_fa, FWD ? 5 : 0);
    chk("fwd1_data", a_fd, FWD ? 16'hBEEF : 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("fwd2_valid", a_fv, FWD);
    chk("fwd2_data", a_fd, FWD ? 16'hBEEF : 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    step(idle);
    chk("fwd_after_flush", a_fv, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rs = mk(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 60),
              DW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom),
              ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 5),
              ($urandom_range(0, 99) < 35));
      step(rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
